// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises the raw request lines, latches rising
// edges as pending, applies a software mask and runs a non-nesting
// request/acknowledge/return handshake with the CPU core.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no interrupt in service; int_req follows pending & mask
// ST_SERVICE | CPU is running the handler of line int_id; waits for int_ret

module interrupt_controller #(
  parameter int               N_IRQ         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               PC_W          = 10,
  parameter logic [PC_W-1:0]  VECTOR_BASE   = 10'h3C0,
  parameter int               VECTOR_STRIDE = 4,
  parameter logic [N_IRQ-1:0] RESET_MASK    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] interruptions,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic             int_req,
  output logic [PC_W-1:0]  int_vector,
  output logic             int_active,
  output logic [2:0]       int_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  typedef enum logic {
    ST_IDLE,
    ST_SERVICE
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] hist_q;
  logic [N_IRQ-1:0] edge_vec;
  logic [N_IRQ-1:0] req_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [2:0]       winner;
  logic [2:0]       vec_sel;
  logic             ack_take;

  // Synchroniser chain per line plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= interruptions;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_vec = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign req_vec  = pending & mask;

  // Lowest-index enabled pending line wins; defaults to 0 when none.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) winner = 3'(i);
    end
  end

  assign int_req    = (state == ST_IDLE) && (|req_vec);
  assign int_active = (state == ST_SERVICE);
  assign ack_take   = int_ack && int_req;
  assign clr_vec    = ack_take ? (N_IRQ'(1) << winner) : '0;

  // Vector tracks the winner while idle and is frozen on int_id in service.
  always_comb begin
    vec_sel    = (state == ST_SERVICE) ? int_id : winner;
    int_vector = VECTOR_BASE + PC_W'(vec_sel) * PC_W'(VECTOR_STRIDE);
  end

  // Handshake FSM with pending and mask registers; a new edge overrides the
  // ack clear so a re-trigger during the ack cycle is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
      mask    <= RESET_MASK;
      int_id  <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | edge_vec;
      if (mask_we) mask <= mask_in;
      case (state)
        ST_IDLE: begin
          if (ack_take) begin
            int_id <= winner;
            state  <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (int_ret) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed walk through the handshake cases
// followed by a random phase, everything compared every cycle against a
// sample-history reference model.

module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interruptions;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [9:0] int_vector;
  logic       int_active;
  logic [2:0] int_id;
  logic [7:0] pending;
  logic [7:0] mask;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending/mask/service state plus the last three input
  // samples; an edge registers two clocks after it is first sampled.
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic       m_busy;
  logic [2:0] m_id;
  logic [7:0] samp [3];

  interrupt_controller dut (
    .clk          (clk),
    .reset        (reset),
    .interruptions(interruptions),
    .mask_we      (mask_we),
    .mask_in      (mask_in),
    .int_ack      (int_ack),
    .int_ret      (int_ret),
    .int_req      (int_req),
    .int_vector   (int_vector),
    .int_active   (int_active),
    .int_id       (int_id),
    .pending      (pending),
    .mask         (mask)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    logic       found;
    r = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_busy = 1'b0;
    m_id   = 3'd0;
    for (int i = 0; i < 3; i++) samp[i] = 8'h00;
  endtask

  task automatic check_outputs();
    logic [7:0] rv;
    logic       e_req;
    int         idx;
    logic [9:0] e_vec;
    rv    = m_busy ? 8'h00 : (m_pend & m_mask);
    e_req = (rv != 8'h00);
    idx   = m_busy ? int'(m_id) : int'(lowest(rv));
    e_vec = 10'((32'h3C0 + idx * 4) % 1024);
    chk("int_req", 32'(int_req), 32'(e_req));
    chk("int_active", 32'(int_active), 32'(m_busy));
    chk("int_vector", 32'(int_vector), 32'(e_vec));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask", 32'(mask), 32'(m_mask));
    if (m_busy) chk("int_id", 32'(int_id), 32'(m_id));
  endtask

  // One clock: predict the model's next state from current inputs, then
  // advance the DUT and compare just after the edge.
  task automatic tick();
    logic [7:0] edges, rv, n_pend, n_mask;
    logic [2:0] win, n_id;
    logic       take, n_busy;
    if (reset) begin
      @(posedge clk);
      #1;
      model_reset();
    end else begin
      edges  = samp[1] & ~samp[2];
      rv     = m_busy ? 8'h00 : (m_pend & m_mask);
      take   = int_ack && (rv != 8'h00);
      win    = lowest(rv);
      n_pend = m_pend;
      if (take) n_pend[win] = 1'b0;
      n_pend = n_pend | edges;
      n_mask = mask_we ? mask_in : m_mask;
      n_busy = m_busy;
      n_id   = m_id;
      if (take) begin
        n_busy = 1'b1;
        n_id   = win;
      end else if (m_busy && int_ret) begin
        n_busy = 1'b0;
      end
      @(posedge clk);
      #1;
      m_pend  = n_pend;
      m_mask  = n_mask;
      m_busy  = n_busy;
      m_id    = n_id;
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = interruptions;
    end
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_ret();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] v);
    mask_we = 1'b1;
    mask_in = v;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    interruptions = 8'h00;
    mask_we       = 1'b0;
    mask_in       = 8'h00;
    int_ack       = 1'b0;
    int_ret       = 1'b0;
    model_reset();
    ticks(2);
    reset = 1'b0;
    tick();
    chk("rst_req", 32'(int_req), 32'h0);
    chk("rst_active", 32'(int_active), 32'h0);
    chk("rst_vector", 32'(int_vector), 32'h3C0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_mask", 32'(mask), 32'h00);

    // Single line 3 pulse, all lines enabled.
    set_mask(8'hFF);
    interruptions = 8'h08;
    ticks(2);
    chk("l3_not_yet", 32'(pending), 32'h00);
    tick();
    chk("l3_pending", 32'(pending), 32'h08);
    chk("l3_req", 32'(int_req), 32'h1);
    chk("l3_vector", 32'(int_vector), 32'h3CC);
    interruptions = 8'h00;
    do_ack();
    do_ret();

    // Lines 5 and 2 together: 2 wins, then 5 after return.
    interruptions = 8'h24;
    ticks(3);
    interruptions = 8'h00;
    chk("p52_vector", 32'(int_vector), 32'h3C8);
    do_ack();
    chk("p52_active", 32'(int_active), 32'h1);
    chk("p52_id", 32'(int_id), 32'h2);
    chk("p52_pending", 32'(pending), 32'h20);
    chk("p52_req", 32'(int_req), 32'h0);
    do_ret();
    chk("p52_rereq", 32'(int_req), 32'h1);
    chk("p52_vec5", 32'(int_vector), 32'h3D4);
    do_ack();
    do_ret();

    // Masked line latches but does not request until unmasked.
    set_mask(8'h00);
    interruptions = 8'h02;
    ticks(3);
    interruptions = 8'h00;
    tick();
    chk("msk_pending", 32'(pending), 32'h02);
    chk("msk_noreq", 32'(int_req), 32'h0);
    set_mask(8'h02);
    chk("msk_unmask_req", 32'(int_req), 32'h1);
    do_ack();
    do_ret();

    // Level held high triggers exactly once.
    set_mask(8'hFF);
    interruptions = 8'h01;
    ticks(3);
    chk("lvl_pending", 32'(pending), 32'h01);
    do_ack();
    do_ret();
    ticks(14);
    chk("lvl_no_retrig", 32'(int_req), 32'h0);
    chk("lvl_pend_clear", 32'(pending), 32'h00);
    interruptions = 8'h00;
    tick();
    interruptions = 8'h01;
    ticks(3);
    chk("lvl_retrig", 32'(int_req), 32'h1);
    interruptions = 8'h00;
    do_ack();
    do_ret();

    // Edge on line 4 lands in the same cycle as its own ack.
    interruptions = 8'h10;
    tick();
    interruptions = 8'h00;
    tick();
    interruptions = 8'h10;
    tick();
    interruptions = 8'h00;
    tick();
    chk("ea_req", 32'(int_req), 32'h1);
    do_ack();
    chk("ea_id", 32'(int_id), 32'h4);
    chk("ea_pend4", 32'(pending[4]), 32'h1);
    do_ret();
    chk("ea_rereq", 32'(int_req), 32'h1);
    chk("ea_vector", 32'(int_vector), 32'h3D0);

    // Async reset in the middle of a service.
    do_ack();
    chk("ar_active_pre", 32'(int_active), 32'h1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_active", 32'(int_active), 32'h0);
    chk("ar_req", 32'(int_req), 32'h0);
    chk("ar_pending", 32'(pending), 32'h00);
    chk("ar_mask", 32'(mask), 32'h00);
    check_outputs();
    tick();
    reset = 1'b0;
    tick();

    // Random phase.
    for (int c = 0; c < 600; c++) begin
      interruptions = interruptions ^ 8'($urandom & $urandom);
      int_ack       = ($urandom_range(0, 2) == 0);
      int_ret       = ($urandom_range(0, 3) == 0);
      mask_we       = ($urandom_range(0, 15) == 0);
      mask_in       = 8'($urandom);
      reset         = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset   = 1'b0;
    int_ack = 1'b0;
    int_ret = 1'b0;
    mask_we = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
